// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: read, write, issue and busy-count signals.
// master = decode/issue/writeback side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW:0]         busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; r0 reads zero and is never busy.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   rf
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      busy_cnt_reg;
  logic [AW:0]      busy_cnt_next;

  assign regs[0]      = '0;
  assign busy_vec[0]  = 1'b0;
  assign busy_next[0] = 1'b0;

  genvar gi;

  // One storage slice per architectural register (r0 has none).
  for (gi = 1; gi < NREGS; gi++) begin : g_reg
    logic [XLEN-1:0] data_reg;
    logic [XLEN-1:0] data_next;
    logic            busy_reg;
    logic            wr_hit;
    logic            iss_hit;

    // Ascending scan so the highest-index matching port wins.
    always_comb begin
      wr_hit    = 1'b0;
      data_next = data_reg;
      for (int p = 0; p < NWR; p++) begin
        if (rf.wr_en[p] && (rf.wr_addr[p*AW +: AW] == AW'(gi))) begin
          wr_hit    = 1'b1;
          data_next = rf.wr_data[p*XLEN +: XLEN];
        end
      end
    end

    assign iss_hit       = rf.iss_en && (rf.iss_addr == AW'(gi));
    // A same-cycle issue overrides the writeback's busy clear.
    assign busy_next[gi] = iss_hit | (busy_reg & ~wr_hit);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= '0;
        busy_reg <= 1'b0;
      end else begin
        data_reg <= data_next;
        busy_reg <= busy_next[gi];
      end
    end

    assign regs[gi]     = data_reg;
    assign busy_vec[gi] = busy_reg;
  end

  always_comb begin
    busy_cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_reg <= '0;
    end else begin
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign rf.busy_cnt = busy_cnt_reg;

  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rf.rd_addr[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    // Forward in-flight write data; busy then only reflects a colliding issue.
    always_comb begin
      data = regs[addr];
      busy = busy_vec[addr];
      if (addr != '0) begin
        for (int p = 0; p < NWR; p++) begin
          if (rf.wr_en[p] && (rf.wr_addr[p*AW +: AW] == addr)) begin
            data = rf.wr_data[p*XLEN +: XLEN];
            busy = rf.iss_en && (rf.iss_addr == addr);
          end
        end
      end
    end
`else
    assign data = regs[addr];
    assign busy = busy_vec[addr];
`endif

    assign rf.rd_data[gi*XLEN +: XLEN] = data;
    assign rf.rd_busy[gi]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against an array-based reference model,
// preceded by directed cases for reset, r0, scoreboard and port-priority rules.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(NREGS);

  logic clk;
  logic rst_n;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) rf ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_busy_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Edge behaviour: writes apply in port order (later port overwrites), then issue sets busy.
  task automatic model_update();
    for (int p = 0; p < NWR; p++) begin
      int a = int'(rf.wr_addr[p*AW +: AW]);
      if (rf.wr_en[p] && a != 0) begin
        m_regs[a] = rf.wr_data[p*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (rf.iss_en && rf.iss_addr != 0) m_busy[int'(rf.iss_addr)] = 1'b1;
  endtask

  task automatic check_reads(input string tag);
    for (int i = 0; i < NRD; i++) begin
      int              a   = int'(rf.rd_addr[i*AW +: AW]);
      logic [XLEN-1:0] e_d = m_regs[a];
      logic            e_b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (a != 0) begin
        for (int p = NWR - 1; p >= 0; p--) begin
          if (rf.wr_en[p] && int'(rf.wr_addr[p*AW +: AW]) == a) begin
            e_d = rf.wr_data[p*XLEN +: XLEN];
            e_b = rf.iss_en && int'(rf.iss_addr) == a;
            break;
          end
        end
      end
`endif
      check_val($sformatf("%s.rd_data%0d", tag, i), 64'(rf.rd_data[i*XLEN +: XLEN]), 64'(e_d));
      check_val($sformatf("%s.rd_busy%0d", tag, i), 64'(rf.rd_busy[i]), 64'(e_b));
    end
    check_val({tag, ".busy_cnt"}, 64'(rf.busy_cnt), 64'(model_busy_count()));
  endtask

  task automatic idle();
    rf.wr_en    = '0;
    rf.wr_addr  = '0;
    rf.wr_data  = '0;
    rf.iss_en   = 1'b0;
    rf.iss_addr = '0;
    rf.rd_addr  = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rf.rd_addr[0*AW +: AW] = AW'(a0);
    rf.rd_addr[1*AW +: AW] = AW'(a1);
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    rf.wr_en[p]              = 1'b1;
    rf.wr_addr[p*AW +: AW]   = AW'(a);
    rf.wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_iss(input int a);
    rf.iss_en   = 1'b1;
    rf.iss_addr = AW'(a);
  endtask

  // One transaction: compare pre-edge outputs, advance the model, take the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_reads(tag);
    $display("txn %-10s we=%b wa=%h/%h is=%b ia=%0d ra=%0d/%0d cnt=%0d", tag, rf.wr_en,
             rf.wr_addr[0*AW +: AW], rf.wr_addr[1*AW +: AW], rf.iss_en, rf.iss_addr,
             rf.rd_addr[0*AW +: AW], rf.rd_addr[1*AW +: AW], rf.busy_cnt);
    if (rst_n) model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    model_clear();

    // Reset state before any clock edge
    set_rd(5, 0);
    #2;
    check_reads("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload r5 and mark it busy, then reset asynchronously mid-cycle
    set_wr(0, 5, 32'hDEADBEEF);
    set_iss(5);
    set_rd(5, 5);
    cycle("preload");
    idle();
    set_rd(5, 5);
    #2;
    check_val("r5_loaded", 64'(rf.rd_data[0 +: XLEN]), 64'hDEADBEEF);
    check_val("r5_busy", 64'(rf.rd_busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_val("arst_data", 64'(rf.rd_data[0 +: XLEN]), 64'd0);
    check_val("arst_busy", 64'(rf.rd_busy[0]), 64'd0);
    check_val("arst_cnt", 64'(rf.busy_cnt), 64'd0);
    cycle("in_reset");
    rst_n = 1'b1;
    #1;

    // Write to r0 is dropped
    set_wr(0, 0, 32'h12345678);
    set_rd(0, 0);
    cycle("wr_r0");
    idle();
    set_rd(0, 0);
    #1;
    check_val("r0_zero", 64'(rf.rd_data[0 +: XLEN]), 64'd0);
    check_val("r0_cnt", 64'(rf.busy_cnt), 64'd0);

    // Issue r7, then writeback clears busy
    set_iss(7);
    set_rd(7, 7);
    cycle("iss_r7");
    idle();
    set_rd(7, 7);
    #1;
    check_val("r7_busy", 64'(rf.rd_busy[0]), 64'd1);
    check_val("r7_cnt", 64'(rf.busy_cnt), 64'd1);
    set_wr(0, 7, 32'hA5A5A5A5);
    cycle("wb_r7");
    idle();
    set_rd(7, 7);
    #1;
    check_val("r7_data", 64'(rf.rd_data[0 +: XLEN]), 64'hA5A5A5A5);
    check_val("r7_idle", 64'(rf.rd_busy[1]), 64'd0);
    check_val("r7_cnt0", 64'(rf.busy_cnt), 64'd0);

    // Issue and write to r3 together: issue wins, data still written
    set_iss(3);
    set_wr(0, 3, 32'h11);
    set_rd(3, 3);
    cycle("iss_wr_r3");
    idle();
    set_rd(3, 3);
    #1;
    check_val("r3_data", 64'(rf.rd_data[0 +: XLEN]), 64'h11);
    check_val("r3_busy", 64'(rf.rd_busy[0]), 64'd1);

    // Both write ports target r9: port 1 wins
    set_wr(0, 9, 32'h1);
    set_wr(1, 9, 32'h2);
    set_rd(9, 3);
    cycle("dual_r9");
    idle();
    set_rd(9, 9);
    #1;
    check_val("r9_data", 64'(rf.rd_data[0 +: XLEN]), 64'h2);

    // Write r4 while reading it on both ports
    set_wr(0, 4, 32'hCAFE);
    set_rd(4, 4);
    #1;
`ifdef REGFILE_BYPASS_EN
    check_val("r4_same", 64'(rf.rd_data[1*XLEN +: XLEN]), 64'hCAFE);
`else
    check_val("r4_same", 64'(rf.rd_data[1*XLEN +: XLEN]), 64'd0);
`endif
    cycle("wr_r4");
    idle();
    set_rd(4, 4);
    #1;
    check_val("r4_after", 64'(rf.rd_data[0 +: XLEN]), 64'hCAFE);

    // Random traffic, addresses biased low to force collisions
    for (int n = 0; n < 400; n++) begin
      int hi = (n % 2 == 0) ? 7 : NREGS - 1;
      idle();
      for (int p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 2) != 0) set_wr(p, $urandom_range(0, hi), $urandom);
      end
      if ($urandom_range(0, 1) != 0) set_iss($urandom_range(0, hi));
      set_rd($urandom_range(0, hi), $urandom_range(0, hi));
      cycle("rand");
    end

    idle();
    set_rd(1, 2);
    @(negedge clk);
    check_reads("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
